// File: rtl/sweep_capture_gate.sv
// rtl/sweep_capture_gate.sv - profile-hop settle gate and fixed-length burst forwarder
//
// Watches the sweeper's profile index. After each hop it waits a programmable
// PLL settle time. It then forwards a burst of capture_len RX samples, each tagged
// with its profile, over a valid/ready stream. After the burst it idles until the
// next hop.
//
// Ports:
//   clk, reset            sample-domain clock, synchronous active-high reset
//   enable                run enable; low returns the gate to IDLE
//   settle_cycles         settle wait, latched when SETTLE is (re)entered
//   capture_len           burst length, latched on entry to CAPTURE (0 acts as 1)
//   profile_i             current profile index from the sweeper
//   s_data, s_valid       RX sample stream (cannot be stalled)
//   m_data, m_profile,
//   m_last, m_valid,
//   m_ready               tagged output stream to the capture/DMA path
//   drop_count            saturating count of samples lost to backpressure
//   abort_count           saturating count of bursts cut short by a profile hop

module sweep_capture_gate #(
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16,
   parameter int PROFILE_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [CNT_W-1:0]     settle_cycles,
   input  logic [CNT_W-1:0]     capture_len,
   input  logic [PROFILE_W-1:0] profile_i,
   input  logic [DATA_W-1:0]    s_data,
   input  logic                 s_valid,
   output logic [DATA_W-1:0]    m_data,
   output logic [PROFILE_W-1:0] m_profile,
   output logic                 m_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [15:0]          drop_count,
   output logic [7:0]           abort_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      CAPTURE  = 2'd2,
      WAIT_CHG = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [PROFILE_W-1:0] profile_q;
   logic [CNT_W-1:0]     settle_cnt, settle_cnt_nxt;
   // Samples still owed in the current burst; the beat loaded while this is 1 is the last.
   logic [CNT_W-1:0]     sample_cnt, sample_cnt_nxt;
   logic                 change;
   logic                 accept;
   logic                 drop;
   logic                 abort;
   logic                 last_beat;

   assign change    = (state != IDLE) && (profile_i != profile_q);
   assign last_beat = (sample_cnt == CNT_W'(1));

   always_comb begin
      state_nxt      = state;
      settle_cnt_nxt = settle_cnt;
      sample_cnt_nxt = sample_cnt;
      accept         = 1'b0;
      drop           = 1'b0;
      abort          = 1'b0;

      // Disable outranks a simultaneous hop, so no counter moves in that cycle.
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_nxt      = SETTLE;
               settle_cnt_nxt = settle_cycles;
            end
            SETTLE: begin
               if (change) begin
                  settle_cnt_nxt = settle_cycles;
               end else if (settle_cnt == '0) begin
                  state_nxt      = CAPTURE;
                  sample_cnt_nxt = (capture_len == '0) ? CNT_W'(1) : capture_len;
               end else begin
                  settle_cnt_nxt = settle_cnt - CNT_W'(1);
               end
            end
            CAPTURE: begin
               if (change) begin
                  // The last beat has not been loaded yet, or we would be in WAIT_CHG.
                  abort          = 1'b1;
                  state_nxt      = SETTLE;
                  settle_cnt_nxt = settle_cycles;
               end else if (s_valid) begin
                  if (!m_valid || m_ready) begin
                     accept         = 1'b1;
                     sample_cnt_nxt = sample_cnt - CNT_W'(1);
                     if (last_beat) begin
                        state_nxt = WAIT_CHG;
                     end
                  end else begin
                     drop = 1'b1;
                  end
               end
            end
            WAIT_CHG: begin
               if (change) begin
                  state_nxt      = SETTLE;
                  settle_cnt_nxt = settle_cycles;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         profile_q   <= '0;
         settle_cnt  <= '0;
         sample_cnt  <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         m_data      <= '0;
         m_profile   <= '0;
         drop_count  <= '0;
         abort_count <= '0;
      end else begin
         state      <= state_nxt;
         profile_q  <= profile_i;
         settle_cnt <= settle_cnt_nxt;
         sample_cnt <= sample_cnt_nxt;

         // The output register only reloads when free or draining, so a stalled beat stays put.
         if (accept) begin
            m_valid   <= 1'b1;
            m_data    <= s_data;
            m_profile <= profile_q;
            m_last    <= last_beat;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end

         if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
         if (abort && (abort_count != 8'hFF)) begin
            abort_count <= abort_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_sweep_capture_gate.sv
// tb/tb_sweep_capture_gate.sv - bench for sweep_capture_gate: directed scenarios plus randomized run against a reference model

module tb_sweep_capture_gate;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] settle_cycles = '0;
   logic [15:0] capture_len = '0;
   logic [2:0]  profile_i = '0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic [2:0]  m_profile;
   logic        m_last;
   logic        m_valid;
   logic [15:0] drop_count;
   logic [7:0]  abort_count;

   int n_cmp = 0;
   int n_err = 0;

   sweep_capture_gate dut (
      .clk(clk), .reset(reset), .enable(enable),
      .settle_cycles(settle_cycles), .capture_len(capture_len),
      .profile_i(profile_i), .s_data(s_data), .s_valid(s_valid),
      .m_data(m_data), .m_profile(m_profile), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready),
      .drop_count(drop_count), .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: burst timing expressed as absolute edge numbers instead of counters.
   int          cyc = 0;
   bit          md_active = 0;
   int          cap_edge = 0;
   int          tgt = 0;
   int          taken = 0;
   logic [2:0]  md_profq = '0;
   logic        md_valid = 0;
   logic [31:0] md_data = '0;
   logic [2:0]  md_prof = '0;
   logic        md_last = 0;
   logic [15:0] md_drop = '0;
   logic [7:0]  md_abort = '0;

   // Handshake log gathered from the DUT output stream.
   int          hs_count = 0;
   int          hs_last_count = 0;
   logic [2:0]  hs_prof = '0;
   logic        hs_last = 0;
   int          beats_by_prof [8];
   int          last_by_prof [8];

   task automatic clear_hs();
      hs_count = 0;
      hs_last_count = 0;
      for (int i = 0; i < 8; i++) begin
         beats_by_prof[i] = 0;
         last_by_prof[i] = 0;
      end
   endtask

   function automatic logic [2:0] other(input logic [2:0] x);
      logic [2:0] d;
      d = 3'($urandom_range(1, 7));
      return x + d;
   endfunction

   task automatic begin_settle();
      // Settle of S cycles: CAPTURE is entered at edge +S+1 and takes its first sample at +S+2.
      cap_edge = cyc + int'(settle_cycles) + 2;
      tgt = 0;
      taken = 0;
   endtask

   task automatic step();
      logic popped;
      logic loaded;
      if (m_valid && m_ready) begin
         hs_count++;
         hs_prof = m_profile;
         hs_last = m_last;
         beats_by_prof[m_profile]++;
         if (m_last) begin
            hs_last_count++;
            last_by_prof[m_profile]++;
         end
      end
      if (reset) begin
         md_active = 0; md_profq = '0; md_valid = 0; md_data = '0; md_prof = '0;
         md_last = 0; md_drop = '0; md_abort = '0; tgt = 0; taken = 0;
      end else begin
         popped = md_valid && m_ready;
         loaded = 0;
         if (!enable) begin
            md_active = 0;
         end else if (!md_active) begin
            md_active = 1;
            begin_settle();
         end else if (profile_i != md_profq) begin
            if (cyc >= cap_edge && taken < tgt && md_abort != 8'hFF) md_abort++;
            begin_settle();
         end else if (cyc == cap_edge - 1) begin
            tgt = (capture_len == 0) ? 1 : int'(capture_len);
            taken = 0;
         end else if (cyc >= cap_edge && taken < tgt && s_valid) begin
            if (!md_valid || m_ready) begin
               md_data = s_data;
               md_prof = md_profq;
               taken++;
               md_last = (taken == tgt);
               loaded = 1;
            end else if (md_drop != 16'hFFFF) begin
               md_drop++;
            end
         end
         if (loaded) md_valid = 1;
         else if (popped) md_valid = 0;
         md_profq = profile_i;
      end
      cyc++;
      @(posedge clk);
      #1;
      s_data = $urandom;
   endtask

   task automatic cycles(input int n);
      repeat (n) step();
   endtask

   task automatic test_reset();
      reset = 1; enable = 0;
      cycles(2);
      reset = 0;
      if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset m_valid got %0b want 0", m_valid); end
      if (m_last !== 1'b0) begin n_err++; $display("FAIL reset m_last got %0b want 0", m_last); end
      if (m_data !== 32'd0) begin n_err++; $display("FAIL reset m_data got %0h want 0", m_data); end
      if (m_profile !== 3'd0) begin n_err++; $display("FAIL reset m_profile got %0d want 0", m_profile); end
      if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset drop_count got %0d want 0", drop_count); end
      if (abort_count !== 8'd0) begin n_err++; $display("FAIL reset abort_count got %0d want 0", abort_count); end
      n_cmp += 6;
   endtask

   task automatic test_settle_latency();
      int n;
      settle_cycles = 4; capture_len = 3; m_ready = 1; s_valid = 1; profile_i = 0; enable = 1;
      cycles(30);
      profile_i = 5;
      step();
      clear_hs();
      n = 0;
      while (n < 20 && !m_valid) begin step(); n++; end
      if (n !== 6) begin n_err++; $display("FAIL latency edges to first m_valid got %0d want 6", n); end
      cycles(12);
      if (hs_count !== 3) begin n_err++; $display("FAIL latency beat count got %0d want 3", hs_count); end
      if (beats_by_prof[5] !== 3) begin n_err++; $display("FAIL latency beats tagged 5 got %0d want 3", beats_by_prof[5]); end
      if (hs_last_count !== 1 || hs_last !== 1'b1) begin
         n_err++; $display("FAIL latency m_last count %0d final %0b want 1/1", hs_last_count, hs_last);
      end
      n_cmp += 4;
   endtask

   task automatic test_zero_len();
      logic [2:0] p;
      settle_cycles = 0; capture_len = 0; m_ready = 1; s_valid = 1;
      cycles(4);
      for (int k = 0; k < 4; k++) begin
         p = other(profile_i);
         profile_i = p;
         clear_hs();
         cycles(6);
         if (hs_count !== 1 || hs_last_count !== 1 || hs_prof !== p) begin
            n_err++;
            $display("FAIL zero_len beats=%0d lasts=%0d prof=%0d want 1/1/%0d", hs_count, hs_last_count, hs_prof, p);
         end
         n_cmp++;
      end
   endtask

   task automatic test_backpressure();
      int n;
      logic [15:0] d0;
      logic [31:0] held;
      settle_cycles = 2; capture_len = 4; m_ready = 1; s_valid = 1;
      profile_i = other(profile_i);
      clear_hs();
      n = 0;
      while (n < 20 && !m_valid) begin step(); n++; end
      if (!m_valid) begin n_err++; $display("FAIL backpressure first beat timeout got 0 want 1"); end
      n_cmp++;
      m_ready = 0;
      d0 = drop_count;
      held = m_data;
      repeat (5) begin
         step();
         if (m_valid !== 1'b1 || m_data !== held) begin
            n_err++; $display("FAIL backpressure held beat valid=%0b data=%0h want 1/%0h", m_valid, m_data, held);
         end
         n_cmp++;
      end
      if (drop_count - d0 !== 16'd5) begin n_err++; $display("FAIL backpressure drops got %0d want 5", drop_count - d0); end
      m_ready = 1;
      cycles(10);
      if (hs_count !== 4 || hs_last_count !== 1 || hs_last !== 1'b1) begin
         n_err++; $display("FAIL backpressure burst beats=%0d lasts=%0d want 4/1", hs_count, hs_last_count);
      end
      n_cmp += 2;
   endtask

   task automatic test_abort();
      int n;
      logic [7:0] a0;
      logic [2:0] p1, p2;
      settle_cycles = 1; capture_len = 8; m_ready = 1; s_valid = 1;
      cycles(12);
      a0 = abort_count;
      p1 = other(profile_i);
      p2 = other(p1);
      profile_i = p1;
      clear_hs();
      n = 0;
      while (n < 30 && hs_count < 2) begin step(); n++; end
      profile_i = p2;
      cycles(20);
      if (abort_count - a0 !== 8'd1) begin n_err++; $display("FAIL abort count delta got %0d want 1", abort_count - a0); end
      if (beats_by_prof[p1] !== 3 || last_by_prof[p1] !== 0) begin
         n_err++; $display("FAIL abort old burst beats=%0d lasts=%0d want 3/0", beats_by_prof[p1], last_by_prof[p1]);
      end
      if (beats_by_prof[p2] !== 8 || last_by_prof[p2] !== 1) begin
         n_err++; $display("FAIL abort new burst beats=%0d lasts=%0d want 8/1", beats_by_prof[p2], last_by_prof[p2]);
      end
      n_cmp += 3;
   endtask

   task automatic test_enable_drop();
      int n;
      logic [31:0] held;
      settle_cycles = 0; capture_len = 5; m_ready = 1; s_valid = 1;
      profile_i = other(profile_i);
      n = 0;
      while (n < 20 && !m_valid) begin step(); n++; end
      m_ready = 0;
      step();
      enable = 0;
      held = m_data;
      step();
      repeat (3) begin
         step();
         if (m_valid !== 1'b1 || m_data !== held) begin
            n_err++; $display("FAIL enable held beat valid=%0b data=%0h want 1/%0h", m_valid, m_data, held);
         end
         n_cmp++;
      end
      m_ready = 1;
      repeat (5) begin
         step();
         if (m_valid !== 1'b0) begin n_err++; $display("FAIL enable idle m_valid got %0b want 0", m_valid); end
         n_cmp++;
      end
      enable = 1;
      n = 0;
      while (n < 10 && !m_valid) begin step(); n++; end
      if (n !== 3) begin n_err++; $display("FAIL enable reentry edges got %0d want 3", n); end
      n_cmp++;
      cycles(10);
   endtask

   task automatic test_reset_mid();
      int n;
      settle_cycles = 1; capture_len = 6; m_ready = 1; s_valid = 1;
      profile_i = other(profile_i);
      n = 0;
      while (n < 20 && !m_valid) begin step(); n++; end
      m_ready = 0;
      step();
      reset = 1;
      step();
      reset = 0;
      m_ready = 1;
      if (m_valid !== 1'b0 || m_last !== 1'b0) begin n_err++; $display("FAIL reset_mid valid/last got %0b/%0b want 0/0", m_valid, m_last); end
      if (m_data !== 32'd0 || m_profile !== 3'd0) begin n_err++; $display("FAIL reset_mid data/prof got %0h/%0d want 0/0", m_data, m_profile); end
      if (drop_count !== 16'd0 || abort_count !== 8'd0) begin
         n_err++; $display("FAIL reset_mid counts got %0d/%0d want 0/0", drop_count, abort_count);
      end
      n_cmp += 3;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) profile_i = other(profile_i);
         s_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if (enable) enable = ($urandom_range(0, 199) != 0);
         else enable = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 29) == 0) settle_cycles = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 29) == 0) capture_len = 16'($urandom_range(0, 6));
         reset = ($urandom_range(0, 499) == 0);
         step();
         if (m_valid !== md_valid) begin n_err++; $display("FAIL rand m_valid cyc=%0d got %0b want %0b", cyc, m_valid, md_valid); end
         if (m_data !== md_data) begin n_err++; $display("FAIL rand m_data cyc=%0d got %0h want %0h", cyc, m_data, md_data); end
         if (m_profile !== md_prof) begin n_err++; $display("FAIL rand m_profile cyc=%0d got %0d want %0d", cyc, m_profile, md_prof); end
         if (m_last !== md_last) begin n_err++; $display("FAIL rand m_last cyc=%0d got %0b want %0b", cyc, m_last, md_last); end
         if (drop_count !== md_drop) begin n_err++; $display("FAIL rand drop_count cyc=%0d got %0d want %0d", cyc, drop_count, md_drop); end
         if (abort_count !== md_abort) begin n_err++; $display("FAIL rand abort_count cyc=%0d got %0d want %0d", cyc, abort_count, md_abort); end
         n_cmp += 6;
      end
      reset = 0;
   endtask

   initial begin
      clear_hs();
      test_reset();
      test_settle_latency();
      test_zero_len();
      test_backpressure();
      test_abort();
      test_enable_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
